// File: rtl/ec_correct_sched.sv
// Round-robin scheduler sharing one error-correcting pipeline among NUM_REQ requesters.
// Optional saturating error counters are built when EC_SCHED_CNT_EN is defined.
module ec_correct_sched #(
    parameter int NUM_REQ   = 4,
    parameter int TAG_WIDTH = 4,
    parameter int PIPE_LAT  = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]   req_tag,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           issue_valid,
    output logic [$clog2(NUM_REQ)-1:0]     issue_sel,
    input  logic                           cor_error,
    input  logic                           non_cor_error,
    input  logic                           mal_error,
    output logic                           rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]     rsp_id,
    output logic [TAG_WIDTH-1:0]           rsp_tag,
    output logic [1:0]                     rsp_status,
    output logic                           halted,
    output logic                           busy,
    input  logic                           clear_halt
`ifdef EC_SCHED_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]           cor_cnt,
    output logic [CNT_WIDTH-1:0]           uncor_cnt,
    output logic [CNT_WIDTH-1:0]           mal_cnt
`endif
);

    localparam int SEL_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t               state;
    logic [SEL_W-1:0]     ptr;
    logic [SEL_W-1:0]     gnt_idx;
    logic [SEL_W-1:0]     cand;
    logic [SEL_W-1:0]     ptr_next;
    logic                 gnt_found;
    logic                 can_grant;
    logic                 hs;
    logic                 head_v;
    logic                 mal_hit;
    logic [1:0]           head_status;
    logic [TAG_WIDTH-1:0] gnt_tag;

    logic [PIPE_LAT:0]    pipe_v;
    logic [SEL_W-1:0]     pipe_id  [PIPE_LAT+1];
    logic [TAG_WIDTH-1:0] pipe_tag [PIPE_LAT+1];

    assign head_v  = pipe_v[PIPE_LAT];
    assign mal_hit = head_v & mal_error;
    // A malfunction at the head blocks issue in the same cycle; reset gating keeps outputs at 0.
    assign can_grant = (state == ST_RUN) & ~mal_hit & ~reset;
    assign hs        = can_grant & gnt_found;
    assign gnt_tag   = req_tag[int'(gnt_idx)*TAG_WIDTH +: TAG_WIDTH];
    assign ptr_next  = (gnt_idx == SEL_W'(NUM_REQ - 1)) ? '0 : gnt_idx + SEL_W'(1);
    assign halted    = (state == ST_HALT);
    assign busy      = |pipe_v;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = SEL_W'((int'(ptr) + k) % NUM_REQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (hs) req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        head_status = 2'b00;
        if (mal_error)          head_status = 2'b11;
        else if (non_cor_error) head_status = 2'b10;
        else if (cor_error)     head_status = 2'b01;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_v <= '0;
            for (int k = 0; k <= PIPE_LAT; k++) begin
                pipe_id[k]  <= '0;
                pipe_tag[k] <= '0;
            end
        end else begin
            pipe_v      <= {pipe_v[PIPE_LAT-1:0], hs};
            pipe_id[0]  <= gnt_idx;
            pipe_tag[0] <= gnt_tag;
            for (int k = 1; k <= PIPE_LAT; k++) begin
                pipe_id[k]  <= pipe_id[k-1];
                pipe_tag[k] <= pipe_tag[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_RUN;
            ptr         <= '0;
            issue_valid <= 1'b0;
            issue_sel   <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_tag     <= '0;
            rsp_status  <= 2'b00;
        end else begin
            issue_valid <= hs;
            if (hs) begin
                issue_sel <= gnt_idx;
                ptr       <= ptr_next;
            end
            rsp_valid <= head_v;
            if (head_v) begin
                rsp_id     <= pipe_id[PIPE_LAT];
                rsp_tag    <= pipe_tag[PIPE_LAT];
                rsp_status <= head_status;
            end
            case (state)
                ST_RUN:   if (mal_hit) state <= ST_DRAIN;
                ST_DRAIN: if (pipe_v == '0) state <= ST_HALT;
                ST_HALT:  if (clear_halt) state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
        end
    end

`ifdef EC_SCHED_CNT_EN
    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cor_cnt   <= '0;
            uncor_cnt <= '0;
            mal_cnt   <= '0;
        end else if (head_v) begin
            if (head_status == 2'b01 && cor_cnt != '1)   cor_cnt   <= cor_cnt + CNT_WIDTH'(1);
            if (head_status == 2'b10 && uncor_cnt != '1) uncor_cnt <= uncor_cnt + CNT_WIDTH'(1);
            if (head_status == 2'b11 && mal_cnt != '1)   mal_cnt   <= mal_cnt + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: doc/ec_correct_sched.md
# ec_correct_sched

Round-robin scheduler that shares one error-correcting correct/select pipeline between NUM_REQ requesters in the TPU result path. It grants one request per cycle, steers the pipeline input mux, and tracks each issued word through the fixed pipeline latency. It tags the returning `cor_error`/`non_cor_error`/`mal_error` flags back to the owning requester. On a malfunction it drains in-flight work and locks out further issue until software clears the halt.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `TAG_WIDTH`, 4: per-request tag width, returned unchanged with the response.
- `PIPE_LAT`, 4: cycles from the pipeline input sample to valid error flags (≥1).
- `CNT_WIDTH`, 16: error counter width.

- `clk`  in  1: single clock, all logic on the rising edge.
- `reset`  in  1: asynchronous, active-high.
- `req_valid`  in  NUM_REQ: per-requester request.
- `req_tag`  in  NUM_REQ*TAG_WIDTH: packed tags, requester i at [i*TAG_WIDTH +: TAG_WIDTH].
- `req_ready`  out  NUM_REQ: one-hot grant, combinational from state and `req_valid`.
- `issue_valid`  out  1: pipeline input qualifier, registered.
- `issue_sel`  out  $clog2(NUM_REQ): pipeline input mux select, registered.
- `cor_error`, `non_cor_error`, `mal_error`  in  1 each: pipeline flags.
- `rsp_valid`  out  1: response strobe, registered.
- `rsp_id`  out  $clog2(NUM_REQ): owning requester.
- `rsp_tag`  out  TAG_WIDTH: tag of the issued request.
- `rsp_status`  out  2: 00 clean, 01 corrected, 10 uncorrectable, 11 malfunction.
- `halted`  out  1: high in HALT.
- `busy`  out  1: any entry in flight.
- `clear_halt`  in  1: single-cycle pulse, leaves HALT.
- `cor_cnt`, `uncor_cnt`, `mal_cnt`  out  CNT_WIDTH each: present only with EC_SCHED_CNT_EN.

## Operation
- Reset values: all outputs 0, state RUN, round-robin pointer 0, in-flight pipe empty.
- Arbitration: in RUN, the grant goes to the first requester with `req_valid`=1, searching from the pointer upward with wrap. A handshake is `req_valid[i] & req_ready[i]`. After a grant to i, the pointer becomes (i+1) mod NUM_REQ. With no requests the pointer holds.
- Issue: on a handshake, the next cycle has `issue_valid`=1 and `issue_sel`=i. Entry {valid, id, tag} enters a PIPE_LAT+1 deep shift pipe.
- Return: when the pipe head is valid, flags are sampled and the response is registered.
  - Status priority: mal > non_cor > cor > clean.
  - Flags arriving with the head invalid are ignored and never counted.
- FSM:
  - RUN → DRAIN on a valid-entry `mal_error`. Grants stop in the same cycle.
  - DRAIN → HALT when the pipe is empty. Remaining entries still return responses with their own flags.
  - HALT → RUN on `clear_halt`. `clear_halt` in RUN or DRAIN is ignored.
- Additional `mal_error` during DRAIN: reported per entry, no state change.
- `busy` = OR of the pipe valid bits.

## Timing
- Handshake at cycle t. Pipeline input `issue_valid` at t+1. Flags sampled at t+1+PIPE_LAT. `rsp_valid` at t+2+PIPE_LAT.
- Full throughput: one grant per cycle. Responses return in issue order.
- A handshake and a `mal_error` in the same cycle: the grant is suppressed. Entering DRAIN takes priority and the requester must hold `req_valid`.
- `clear_halt` in HALT: `halted` drops on the next cycle. The first grant is possible in that same next cycle.
- Reset mid-operation: in-flight entries are discarded and no responses are issued. Counters clear.

## Configuration
- `EC_SCHED_CNT_EN` defined:
  - Three saturating counters (stick at 2^CNT_WIDTH−1) increment once per valid response of status 01, 10 and 11 respectively.
  - Counters clear only on `reset`.
- `EC_SCHED_CNT_EN` undefined: counter ports and logic are absent. All other behaviour is identical.

## Test plan
- NUM_REQ=4, PIPE_LAT=4, all `req_valid` held high from cycle 0, all flags 0 → grants 0,1,2,3,0…. First `rsp_valid` at cycle 6 with `rsp_id`=0, status 00. One response per cycle after that.
- Requester 2 alone, tag 4'hA, with `cor_error`=1 at the sample cycle → response id 2, tag A, status 01. `cor_cnt`=1 with the macro defined.
- Three back-to-back issues, `mal_error` on the first response → grants stop that cycle. The second and third responses still arrive. `halted`=1 once the pipe empties. A `clear_halt` pulse resumes grants the next cycle.
- `cor_error` and `non_cor_error` both high on one entry → status 10, and `cor_cnt` is unchanged.
- CNT_WIDTH=2, five uncorrectable responses → `uncor_cnt` saturates at 3.
- `reset` asserted with 3 entries in flight → no `rsp_valid` ever for them, and all outputs read 0 during reset.
